calc2_req_sched: RTL and testbench

Request scheduler placed between the four calc2 requester ports and the shared adder and shifter units. It captures two-cycle port commands (command plus operand 1, then operand 2), arbitrates them round-robin onto each unit over a valid/ready handshake, and routes unit results back to the owning port's response outputs. Invalid commands are answered locally and never reach a unit.

---
 rtl/calc2_sched_pkg.sv | 47 ++++
 rtl/calc2_rr_arb.sv | 51 +++++
 rtl/calc2_req_sched.sv | 256 +++++++++++++++++++++++++
 tb/tb_calc2_req_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/calc2_sched_pkg.sv
// Shared definitions for the calc2 request scheduler: command/response encodings,
// capture FSM states and the unit request / port response records.
package calc2_sched_pkg;

    localparam int NPORT = 4;
    localparam int DW    = 32;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP2  = 2'd1,
        ST_PEND = 2'd2,
        ST_INV  = 2'd3
    } cap_state_e;

    typedef struct packed {
        logic [3:0]    cmd;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [1:0]    tag;
        logic [1:0]    port;
    } disp_t;

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
        logic [1:0]    tag;
    } resp_t;

    function automatic logic is_add_cmd(input logic [3:0] cmd);
        return (cmd == CMD_ADD) || (cmd == CMD_SUB);
    endfunction

    function automatic logic is_shf_cmd(input logic [3:0] cmd);
        return (cmd == CMD_SHL) || (cmd == CMD_SHR);
    endfunction

endpackage

// File: rtl/calc2_rr_arb.sv
// Four-request arbiter with a round-robin pointer that advances past each accepted grant.
// Defining CALC2_SCHED_FIXED_PRIO_EN replaces the pointer with fixed priority (port index 0 highest).
module calc2_rr_arb
    import calc2_sched_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NPORT-1:0] req,
    input  logic             acc,
    input  logic [1:0]       acc_idx,
    output logic             gnt_vld,
    output logic [1:0]       gnt_idx
);

    logic [1:0]       ptr_s;
    logic [NPORT-1:0] rot_s;
    logic [1:0]       off_s;

`ifdef CALC2_SCHED_FIXED_PRIO_EN
    assign ptr_s = 2'd0;
`else
    logic [1:0] ptr_r;

    // Pointer register: moves one past the port whose grant was just accepted.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_r <= 2'd0;
        end else if (acc) begin
            ptr_r <= acc_idx + 2'd1;
        end
    end

    assign ptr_s = ptr_r;
`endif

    // Rotate so the pointer position is bit 0, then take the lowest set request.
    always_comb begin
        rot_s   = 4'({req, req} >> ptr_s);
        gnt_vld = 1'b1;
        off_s   = 2'd0;
        casez (rot_s)
            4'b???1: off_s   = 2'd0;
            4'b??10: off_s   = 2'd1;
            4'b?100: off_s   = 2'd2;
            4'b1000: off_s   = 2'd3;
            default: gnt_vld = 1'b0;
        endcase
        gnt_idx = ptr_s + off_s;
    end

endmodule

// File: rtl/calc2_req_sched.sv
// calc2 request scheduler: captures two-cycle port commands, dispatches them to the adder and
// shifter, and routes results back. CALC2_SCHED_FIXED_PRIO_EN selects fixed-priority dispatch.
module calc2_req_sched
    import calc2_sched_pkg::*;
(
    input  logic         c_clk,
    input  logic         reset_n,
    input  logic [15:0]  req_cmd_in,
    input  logic [127:0] req_data_in,
    input  logic [7:0]   req_tag_in,
    output logic [3:0]   port_busy,
    output logic         add_vld,
    input  logic         add_rdy,
    output logic [3:0]   add_cmd,
    output logic [31:0]  add_op1,
    output logic [31:0]  add_op2,
    output logic [1:0]   add_tag,
    output logic [1:0]   add_port,
    output logic         shf_vld,
    input  logic         shf_rdy,
    output logic [3:0]   shf_cmd,
    output logic [31:0]  shf_op1,
    output logic [31:0]  shf_op2,
    output logic [1:0]   shf_tag,
    output logic [1:0]   shf_port,
    input  logic         add_res_vld,
    input  logic [1:0]   add_res_port,
    input  logic [1:0]   add_res_resp,
    input  logic [31:0]  add_res_data,
    input  logic [1:0]   add_res_tag,
    input  logic         shf_res_vld,
    input  logic [1:0]   shf_res_port,
    input  logic [1:0]   shf_res_resp,
    input  logic [31:0]  shf_res_data,
    input  logic [1:0]   shf_res_tag,
    output logic         shf_res_rdy,
    output logic [7:0]   out_resp,
    output logic [127:0] out_data,
    output logic [7:0]   out_tag
);

    cap_state_e       state_r     [NPORT];
    cap_state_e       state_nxt_s [NPORT];
    logic [3:0]       cmd_r       [NPORT];
    logic [DW-1:0]    op1_r       [NPORT];
    logic [DW-1:0]    op2_r       [NPORT];
    logic [1:0]       tag_r       [NPORT];
    logic [3:0]       cmd_in_s    [NPORT];
    logic [DW-1:0]    data_in_s   [NPORT];
    logic [1:0]       tag_in_s    [NPORT];
    resp_t            resp_nxt_s  [NPORT];
    resp_t            resp_r      [NPORT];

    logic [NPORT-1:0] add_req_s, shf_req_s, add_take_s, shf_take_s, inv_fire_s;
    logic             add_acc_s, shf_acc_s, add_load_s, shf_load_s;
    logic             add_gnt_vld_s, shf_gnt_vld_s;
    logic [1:0]       add_gnt_idx_s, shf_gnt_idx_s;
    disp_t            add_pay_s, shf_pay_s, add_pay_r, shf_pay_r;
    logic             add_vld_r, shf_vld_r;
    logic             shf_res_rdy_s, shf_res_take_s;

    // Split the packed per-port request buses.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            cmd_in_s[p]  = req_cmd_in[4*p +: 4];
            data_in_s[p] = req_data_in[DW*p +: DW];
            tag_in_s[p]  = req_tag_in[2*p +: 2];
        end
    end

    // Eligibility: a port in OP2 competes already so its grant lands the cycle PEND is entered.
    always_comb begin
        add_acc_s  = add_vld_r && add_rdy;
        shf_acc_s  = shf_vld_r && shf_rdy;
        add_load_s = !add_vld_r || add_rdy;
        shf_load_s = !shf_vld_r || shf_rdy;
        for (int p = 0; p < NPORT; p++) begin
            add_req_s[p]  = ((state_r[p] == ST_OP2) || (state_r[p] == ST_PEND)) && is_add_cmd(cmd_r[p])
                            && !(add_vld_r && (add_pay_r.port == 2'(p)));
            shf_req_s[p]  = ((state_r[p] == ST_OP2) || (state_r[p] == ST_PEND)) && is_shf_cmd(cmd_r[p])
                            && !(shf_vld_r && (shf_pay_r.port == 2'(p)));
            add_take_s[p] = add_acc_s && (add_pay_r.port == 2'(p));
            shf_take_s[p] = shf_acc_s && (shf_pay_r.port == 2'(p));
        end
    end

    calc2_rr_arb u_add_arb (
        .clk     (c_clk),
        .reset_n (reset_n),
        .req     (add_req_s),
        .acc     (add_acc_s),
        .acc_idx (add_pay_r.port),
        .gnt_vld (add_gnt_vld_s),
        .gnt_idx (add_gnt_idx_s)
    );

    calc2_rr_arb u_shf_arb (
        .clk     (c_clk),
        .reset_n (reset_n),
        .req     (shf_req_s),
        .acc     (shf_acc_s),
        .acc_idx (shf_pay_r.port),
        .gnt_vld (shf_gnt_vld_s),
        .gnt_idx (shf_gnt_idx_s)
    );

    // Build the winning payloads; op2 comes straight from the bus while the port is still in OP2.
    always_comb begin
        add_pay_s.cmd  = cmd_r[add_gnt_idx_s];
        add_pay_s.op1  = op1_r[add_gnt_idx_s];
        add_pay_s.op2  = (state_r[add_gnt_idx_s] == ST_OP2) ? data_in_s[add_gnt_idx_s] : op2_r[add_gnt_idx_s];
        add_pay_s.tag  = tag_r[add_gnt_idx_s];
        add_pay_s.port = add_gnt_idx_s;
        shf_pay_s.cmd  = cmd_r[shf_gnt_idx_s];
        shf_pay_s.op1  = op1_r[shf_gnt_idx_s];
        shf_pay_s.op2  = (state_r[shf_gnt_idx_s] == ST_OP2) ? data_in_s[shf_gnt_idx_s] : op2_r[shf_gnt_idx_s];
        shf_pay_s.tag  = tag_r[shf_gnt_idx_s];
        shf_pay_s.port = shf_gnt_idx_s;
    end

    // Unit request registers: reloaded only when the slot is empty or being accepted.
    always_ff @(posedge c_clk) begin
        if (!reset_n) begin
            add_vld_r <= 1'b0;
            shf_vld_r <= 1'b0;
            add_pay_r <= '0;
            shf_pay_r <= '0;
        end else begin
            if (add_load_s) begin
                add_vld_r <= add_gnt_vld_s;
                if (add_gnt_vld_s) begin
                    add_pay_r <= add_pay_s;
                end
            end
            if (shf_load_s) begin
                shf_vld_r <= shf_gnt_vld_s;
                if (shf_gnt_vld_s) begin
                    shf_pay_r <= shf_pay_s;
                end
            end
        end
    end

    // Per-port response selection: adder result beats shifter result beats local INV answer.
    always_comb begin
        shf_res_rdy_s  = !(shf_res_vld && add_res_vld && (shf_res_port == add_res_port));
        shf_res_take_s = shf_res_vld && shf_res_rdy_s;
        for (int p = 0; p < NPORT; p++) begin
            resp_nxt_s[p] = '0;
            inv_fire_s[p] = 1'b0;
            if (add_res_vld && (add_res_port == 2'(p))) begin
                resp_nxt_s[p].resp = add_res_resp;
                resp_nxt_s[p].data = add_res_data;
                resp_nxt_s[p].tag  = add_res_tag;
            end else if (shf_res_take_s && (shf_res_port == 2'(p))) begin
                resp_nxt_s[p].resp = shf_res_resp;
                resp_nxt_s[p].data = shf_res_data;
                resp_nxt_s[p].tag  = shf_res_tag;
            end else if (state_r[p] == ST_INV) begin
                resp_nxt_s[p].resp = RESP_ERR;
                resp_nxt_s[p].tag  = tag_r[p];
                inv_fire_s[p]      = 1'b1;
            end else begin
                resp_nxt_s[p].resp = RESP_NONE;
            end
        end
    end

    // Capture FSM next state per port.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            state_nxt_s[p] = state_r[p];
            case (state_r[p])
                ST_IDLE: begin
                    if (cmd_in_s[p] != CMD_NOP) state_nxt_s[p] = ST_OP2;
                    else                        state_nxt_s[p] = ST_IDLE;
                end
                ST_OP2: begin
                    if (is_add_cmd(cmd_r[p]) || is_shf_cmd(cmd_r[p])) state_nxt_s[p] = ST_PEND;
                    else                                              state_nxt_s[p] = ST_INV;
                end
                ST_PEND: begin
                    if (add_take_s[p] || shf_take_s[p]) state_nxt_s[p] = ST_IDLE;
                    else                                state_nxt_s[p] = ST_PEND;
                end
                ST_INV: begin
                    if (inv_fire_s[p]) state_nxt_s[p] = ST_IDLE;
                    else               state_nxt_s[p] = ST_INV;
                end
                default: state_nxt_s[p] = ST_IDLE;
            endcase
        end
    end

    // Capture FSM state register.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset_n) state_r[p] <= ST_IDLE;
            else          state_r[p] <= state_nxt_s[p];
        end
    end

    // Command capture: cmd/op1/tag in the command cycle, op2 in the following one.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset_n) begin
                cmd_r[p] <= CMD_NOP;
                op1_r[p] <= '0;
                op2_r[p] <= '0;
                tag_r[p] <= 2'd0;
            end else begin
                if ((state_r[p] == ST_IDLE) && (cmd_in_s[p] != CMD_NOP)) begin
                    cmd_r[p] <= cmd_in_s[p];
                    op1_r[p] <= data_in_s[p];
                    tag_r[p] <= tag_in_s[p];
                end
                if (state_r[p] == ST_OP2) begin
                    op2_r[p] <= data_in_s[p];
                end
            end
        end
    end

    // Response registers: single-cycle pulse per delivered response.
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NPORT; p++) begin
            if (!reset_n) resp_r[p] <= '0;
            else          resp_r[p] <= resp_nxt_s[p];
        end
    end

    // Pack per-port response and busy state onto the output buses.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            out_resp[2*p +: 2]   = resp_r[p].resp;
            out_data[DW*p +: DW] = resp_r[p].data;
            out_tag[2*p +: 2]    = resp_r[p].tag;
            port_busy[p]         = (state_r[p] != ST_IDLE);
        end
    end

    assign add_vld     = add_vld_r;
    assign add_cmd     = add_pay_r.cmd;
    assign add_op1     = add_pay_r.op1;
    assign add_op2     = add_pay_r.op2;
    assign add_tag     = add_pay_r.tag;
    assign add_port    = add_pay_r.port;
    assign shf_vld     = shf_vld_r;
    assign shf_cmd     = shf_pay_r.cmd;
    assign shf_op1     = shf_pay_r.op1;
    assign shf_op2     = shf_pay_r.op2;
    assign shf_tag     = shf_pay_r.tag;
    assign shf_port    = shf_pay_r.port;
    assign shf_res_rdy = shf_res_rdy_s;

endmodule

// File: tb/tb_calc2_req_sched.sv
// Directed self-checking bench for calc2_req_sched; expected values are hand-computed per step.
module tb_calc2_req_sched;

    logic         c_clk = 1'b0;
    logic         reset_n;
    logic [15:0]  req_cmd_in;
    logic [127:0] req_data_in;
    logic [7:0]   req_tag_in;
    logic [3:0]   port_busy;
    logic         add_vld, add_rdy, shf_vld, shf_rdy;
    logic [3:0]   add_cmd, shf_cmd;
    logic [31:0]  add_op1, add_op2, shf_op1, shf_op2;
    logic [1:0]   add_tag, add_port, shf_tag, shf_port;
    logic         add_res_vld, shf_res_vld, shf_res_rdy;
    logic [1:0]   add_res_port, add_res_resp, add_res_tag;
    logic [1:0]   shf_res_port, shf_res_resp, shf_res_tag;
    logic [31:0]  add_res_data, shf_res_data;
    logic [7:0]   out_resp, out_tag;
    logic [127:0] out_data;

    int checks = 0;
    int errors = 0;
    int rr_a, rr_b, mix_a, mix_b;

    always #5 c_clk = ~c_clk;

    calc2_req_sched dut (
        .c_clk(c_clk), .reset_n(reset_n),
        .req_cmd_in(req_cmd_in), .req_data_in(req_data_in), .req_tag_in(req_tag_in),
        .port_busy(port_busy),
        .add_vld(add_vld), .add_rdy(add_rdy), .add_cmd(add_cmd), .add_op1(add_op1),
        .add_op2(add_op2), .add_tag(add_tag), .add_port(add_port),
        .shf_vld(shf_vld), .shf_rdy(shf_rdy), .shf_cmd(shf_cmd), .shf_op1(shf_op1),
        .shf_op2(shf_op2), .shf_tag(shf_tag), .shf_port(shf_port),
        .add_res_vld(add_res_vld), .add_res_port(add_res_port), .add_res_resp(add_res_resp),
        .add_res_data(add_res_data), .add_res_tag(add_res_tag),
        .shf_res_vld(shf_res_vld), .shf_res_port(shf_res_port), .shf_res_resp(shf_res_resp),
        .shf_res_data(shf_res_data), .shf_res_tag(shf_res_tag), .shf_res_rdy(shf_res_rdy),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag)
    );

    task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic chk_add(input string name, input int p, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [3:0] cmd, input logic [1:0] tag);
        chk(name, {add_vld, add_cmd, add_op1, add_op2, add_tag, add_port},
            {1'b1, cmd, op1, op2, tag, 2'(p)});
    endtask

    task automatic chk_shf(input string name, input int p, input logic [31:0] op1,
                           input logic [31:0] op2, input logic [3:0] cmd, input logic [1:0] tag);
        chk(name, {shf_vld, shf_cmd, shf_op1, shf_op2, shf_tag, shf_port},
            {1'b1, cmd, op1, op2, tag, 2'(p)});
    endtask

    task automatic set_port(input int p, input logic [3:0] cmd, input logic [31:0] data, input logic [1:0] tag);
        req_cmd_in[4*p +: 4]   = cmd;
        req_data_in[32*p +: 32] = data;
        req_tag_in[2*p +: 2]   = tag;
    endtask

    task automatic tick;
        @(posedge c_clk);
        #2;
    endtask

    initial begin
`ifdef CALC2_SCHED_FIXED_PRIO_EN
        rr_a = 0; rr_b = 3; mix_a = 0; mix_b = 1;
`else
        rr_a = 3; rr_b = 0; mix_a = 1; mix_b = 0;
`endif
        reset_n = 1'b0;
        req_cmd_in = 16'd0; req_data_in = 128'd0; req_tag_in = 8'd0;
        add_rdy = 1'b1; shf_rdy = 1'b1;
        add_res_vld = 1'b0; add_res_port = 2'd0; add_res_resp = 2'd0; add_res_data = 32'd0; add_res_tag = 2'd0;
        shf_res_vld = 1'b0; shf_res_port = 2'd0; shf_res_resp = 2'd0; shf_res_data = 32'd0; shf_res_tag = 2'd0;
        tick; tick;
        chk("rst_busy", port_busy, 4'd0);
        chk("rst_vld", {add_vld, shf_vld}, 2'd0);
        chk("rst_resp", out_resp, 8'd0);
        reset_n = 1'b1;

        // All four ports issue sub together: grants port1..port4 back to back
        for (int p = 0; p < 4; p++) set_port(p, 4'd2, 32'h10 + p, 2'(p));
        tick;
        for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'h20 + p, 2'd0);
        chk("burst_busy", port_busy, 4'hF);
        chk("burst_novld", add_vld, 1'b0);
        tick;
        req_data_in = 128'd0;
        for (int k = 0; k < 4; k++) begin
            chk_add($sformatf("burst_g%0d", k), k, 32'h10 + k, 32'h20 + k, 4'd2, 2'(k));
            tick;
        end
        chk("burst_end_vld", add_vld, 1'b0);
        chk("burst_end_busy", port_busy, 4'd0);

        // Single add on port 1 and its result routed back
        set_port(0, 4'd1, 32'd10, 2'd1);
        tick;
        set_port(0, 4'd0, 32'd25, 2'd0);
        chk("single_early", add_vld, 1'b0);
        tick;
        set_port(0, 4'd0, 32'd0, 2'd0);
        chk_add("single_disp", 0, 32'd10, 32'd25, 4'd1, 2'd1);
        tick;
        chk("single_done", add_vld, 1'b0);
        add_res_vld = 1'b1; add_res_port = 2'd0; add_res_resp = 2'd1; add_res_data = 32'd35; add_res_tag = 2'd1;
        tick;
        add_res_vld = 1'b0;
        chk("single_resp", {out_resp[1:0], out_data[31:0], out_tag[1:0]}, {2'd1, 32'd35, 2'd1});
        tick;
        chk("single_pulse", out_resp[1:0], 2'd0);

        // Pointer now past port 1: ports 1 and 4 together resolve in rotated order
        set_port(0, 4'd1, 32'h1, 2'd0);
        set_port(3, 4'd2, 32'h4, 2'd3);
        tick;
        set_port(0, 4'd0, 32'h11, 2'd0);
        set_port(3, 4'd0, 32'h44, 2'd0);
        tick;
        req_data_in = 128'd0;
        chk_add("rr_first", rr_a, (rr_a == 3) ? 32'h4 : 32'h1, (rr_a == 3) ? 32'h44 : 32'h11,
                (rr_a == 3) ? 4'd2 : 4'd1, 2'(rr_a));
        tick;
        chk_add("rr_second", rr_b, (rr_b == 3) ? 32'h4 : 32'h1, (rr_b == 3) ? 32'h44 : 32'h11,
                (rr_b == 3) ? 4'd2 : 4'd1, 2'(rr_b));
        tick;
        chk("rr_end", add_vld, 1'b0);

        // Mixed adds and shifts; adder stalled three cycles while the shifter drains
        for (int p = 0; p < 4; p++) set_port(p, (p < 2) ? 4'd1 : 4'd5, 32'd100 + p, 2'(p));
        add_rdy = 1'b0;
        tick;
        for (int p = 0; p < 4; p++) set_port(p, 4'd0, 32'd200 + p, 2'd0);
        tick;
        req_data_in = 128'd0;
        chk_add("mix_a0", mix_a, 32'd100 + mix_a, 32'd200 + mix_a, 4'd1, 2'(mix_a));
        chk_shf("mix_s0", 2, 32'd102, 32'd202, 4'd5, 2'd2);
        tick;
        chk_add("mix_a1", mix_a, 32'd100 + mix_a, 32'd200 + mix_a, 4'd1, 2'(mix_a));
        chk_shf("mix_s1", 3, 32'd103, 32'd203, 4'd5, 2'd3);
        tick;
        chk_add("mix_a2", mix_a, 32'd100 + mix_a, 32'd200 + mix_a, 4'd1, 2'(mix_a));
        chk("mix_s_done", shf_vld, 1'b0);
        tick;
        add_rdy = 1'b1;
        chk_add("mix_a3", mix_a, 32'd100 + mix_a, 32'd200 + mix_a, 4'd1, 2'(mix_a));
        tick;
        chk_add("mix_b", mix_b, 32'd100 + mix_b, 32'd200 + mix_b, 4'd1, 2'(mix_b));
        tick;
        chk("mix_end", add_vld, 1'b0);

        // Invalid command on port 2 answered locally
        set_port(1, 4'd3, 32'h55, 2'd3);
        tick;
        set_port(1, 4'd0, 32'h66, 2'd0);
        chk("inv_busy1", {port_busy[1], add_vld, shf_vld}, 3'b100);
        tick;
        req_data_in = 128'd0;
        chk("inv_busy2", {port_busy[1], add_vld, shf_vld}, 3'b100);
        tick;
        chk("inv_resp", {out_resp[3:2], out_data[63:32], out_tag[3:2], port_busy[1]}, {2'd2, 32'd0, 2'd3, 1'b0});
        tick;
        chk("inv_pulse", out_resp[3:2], 2'd0);

        // Adder and shifter results for port 3 in the same cycle
        add_res_vld = 1'b1; add_res_port = 2'd2; add_res_resp = 2'd1; add_res_data = 32'hAAA; add_res_tag = 2'd1;
        shf_res_vld = 1'b1; shf_res_port = 2'd2; shf_res_resp = 2'd2; shf_res_data = 32'hBBB; shf_res_tag = 2'd2;
        #1;
        chk("col_rdy0", shf_res_rdy, 1'b0);
        tick;
        add_res_vld = 1'b0;
        #1;
        chk("col_rdy1", shf_res_rdy, 1'b1);
        chk("col_add", {out_resp[5:4], out_data[95:64], out_tag[5:4]}, {2'd1, 32'hAAA, 2'd1});
        tick;
        shf_res_vld = 1'b0;
        chk("col_shf", {out_resp[5:4], out_data[95:64], out_tag[5:4]}, {2'd2, 32'hBBB, 2'd2});

        // Results for different ports in one cycle are both delivered
        add_res_vld = 1'b1; add_res_port = 2'd0; add_res_resp = 2'd1; add_res_data = 32'h123; add_res_tag = 2'd2;
        shf_res_vld = 1'b1; shf_res_port = 2'd1; shf_res_resp = 2'd1; shf_res_data = 32'h456; shf_res_tag = 2'd3;
        #1;
        chk("dual_rdy", shf_res_rdy, 1'b1);
        tick;
        add_res_vld = 1'b0; shf_res_vld = 1'b0;
        chk("dual_p0", {out_resp[1:0], out_data[31:0], out_tag[1:0]}, {2'd1, 32'h123, 2'd2});
        chk("dual_p1", {out_resp[3:2], out_data[63:32], out_tag[3:2]}, {2'd1, 32'h456, 2'd3});

        // Reset while port 4 is pending drops the request silently
        add_rdy = 1'b0;
        set_port(3, 4'd1, 32'h7, 2'd2);
        tick;
        set_port(3, 4'd0, 32'h8, 2'd0);
        tick;
        req_data_in = 128'd0;
        chk_add("rst_pend", 3, 32'h7, 32'h8, 4'd1, 2'd2);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        add_rdy = 1'b1;
        chk("rst_drop", {add_vld, port_busy}, 5'd0);
        tick;
        chk("rst_quiet1", {add_vld, out_resp}, 9'd0);
        tick;
        chk("rst_quiet2", {add_vld, out_resp}, 9'd0);

        // Fresh request after reset completes normally
        set_port(3, 4'd2, 32'h30, 2'd1);
        tick;
        set_port(3, 4'd0, 32'h12, 2'd0);
        tick;
        req_data_in = 128'd0;
        chk_add("fresh_disp", 3, 32'h30, 32'h12, 4'd2, 2'd1);
        tick;
        chk("fresh_done", add_vld, 1'b0);
        add_res_vld = 1'b1; add_res_port = 2'd3; add_res_resp = 2'd1; add_res_data = 32'h1E; add_res_tag = 2'd1;
        tick;
        add_res_vld = 1'b0;
        chk("fresh_resp", {out_resp[7:6], out_data[127:96], out_tag[7:6]}, {2'd1, 32'h1E, 2'd1});
        tick;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
